// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit add/subtract sequencer driving one shared 4-bit adder slice,
// least-significant nibble first, one nibble per clock.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             sub,
    output logic             busy,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             done
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic             carry;
    logic [IW-1:0]    idx;

    // Handshake: start is taken at a rising edge only in IDLE or DONE; busy is
    // high for exactly NIBBLES cycles afterwards, then done pulses for one
    // cycle with result/cout/ovf already valid. start during busy is dropped.
    assign busy = (state == RUN);

    always_comb begin
        work_next = work;
        work_next[4*idx +: 4] = add_sum;
    end

    // The slice sees only registered operands and carry, so add_cout never
    // loops back to add_cin within a cycle.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[4*idx +: 4];
            add_b   = b_reg[4*idx +: 4];
            add_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            work   <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= op_a;
                        b_reg <= sub ? ~op_b : op_b;
                        carry <= sub ? 1'b1 : op_cin;
                        idx   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= add_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // Signed overflow: operands agree in sign, sum does not.
                        state  <= DONE;
                        idx    <= '0;
                        result <= work_next;
                        cout   <= add_cout;
                        ovf    <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                  (add_sum[3] != a_reg[WIDTH-1]);
                        done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl (WIDTH=16) with a
// behavioural 4-bit adder slice attached.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             op_cin = 1'b0;
    logic             sub = 1'b0;
    logic             busy;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    // expected {add_cin, add_b, add_a} per RUN cycle
    logic [8:0] exp_q[$];

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_cin   (op_cin),
        .sub      (sub),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf),
        .done     (done)
    );

    // external ripple-carry slice
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_expected(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic s);
        logic [WIDTH-1:0] bb;
        logic [4:0]       sum5;
        logic [3:0]       na;
        logic [3:0]       nb;
        logic             c;
        bb = s ? ~b : b;
        c  = s ? 1'b1 : cin;
        exp_q.delete();
        for (int k = 0; k < NIBBLES; k++) begin
            na = a[4*k +: 4];
            nb = bb[4*k +: 4];
            exp_q.push_back({c, nb, na});
            sum5 = {1'b0, na} + {1'b0, nb} + {4'h0, c};
            c = sum5[4];
        end
    endtask

    // Runs one op; poke >= 0 raises start (with junk operands) for the edge
    // ending RUN cycle poke+1, which must be ignored.
    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic s, input logic [WIDTH-1:0] exp_res,
                          input logic exp_cout, input logic exp_ovf, input int poke);
        logic [8:0] e;
        load_expected(a, b, cin, s);
        @(negedge clk);
        op_a = a; op_b = b; op_cin = cin; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NIBBLES; k++) begin
            check({name, " busy"}, 32'(busy), 32'd1);
            check({name, " done_low"}, 32'(done), 32'd0);
            e = exp_q.pop_front();
            check({name, " slice"}, 32'({add_cin, add_b, add_a}), 32'(e));
            if (k == poke) begin
                start = 1'b1; op_a = 16'hDEAD; op_b = 16'hBEEF; op_cin = 1'b1; sub = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " busy_done"}, 32'(busy), 32'd0);
        check({name, " result"}, 32'(result), 32'(exp_res));
        check({name, " cout"}, 32'(cout), 32'(exp_cout));
        check({name, " ovf"}, 32'(ovf), 32'(exp_ovf));
        check({name, " slice_idle"}, 32'({add_cin, add_b, add_a}), 32'd0);
        @(negedge clk);
        check({name, " done_pulse"}, 32'(done), 32'd0);
        check({name, " idle"}, 32'(busy), 32'd0);
        check({name, " result_hold"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        check("rst slice", 32'({add_cin, add_b, add_a}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add1", 16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0, -1);
        run_op("addff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, -1);
        run_op("sub57", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, -1);
        run_op("sub8k", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, -1);
        run_op("add7f", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, -1);
        run_op("poke", 16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0, 1);

        // start held across two ops: done after E4 and E9
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int t = 0; t <= 9; t++) begin
            @(negedge clk);
            if (t == 0) begin
                op_a = 16'hABCD; op_b = 16'h1234;
            end
            check("b2b done", 32'(done), 32'((t == 4) || (t == 9)));
            check("b2b busy", 32'(busy), 32'((t != 4) && (t != 9)));
            if (t == 4) check("b2b result1", 32'(result), 32'h3333);
            if (t == 9) begin
                check("b2b result2", 32'(result), 32'hBE01);
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b idle", 32'(done), 32'd0);

        // asynchronous reset between E2 and E3
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h0F0F; op_cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(done), 32'd0);
        check("arst result", 32'(result), 32'd0);
        check("arst slice", 32'({add_cin, add_b, add_a}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check("arst no_done", 32'(done), 32'd0);
        end
        run_op("post", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external 4-bit ripple-carry adder slice, least-significant nibble first, one nibble per clock. The block owns the operand/carry registers and the start/done handshake. It drives the slice's a/b/cin and reads back its sum/cout combinationally. It sits between the arithmetic-unit front end and the shared 4-bit adder instance.

Parameters:
WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8. NIBBLES = WIDTH/4 is a derived localparam.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when not busy
op_a  in  WIDTH  operand A, latched on acceptance
op_b  in  WIDTH  operand B, latched on acceptance
op_cin  in  1  carry-in for add; ignored when sub=1
sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1)
busy  out  1  high while nibbles are being processed
add_a  out  4  nibble of A to the adder slice
add_b  out  4  nibble of B (post-inversion) to the adder slice
add_cin  out  1  carry to the adder slice
add_sum  in  4  slice sum (combinational from add_a/add_b/add_cin)
add_cout  in  1  slice carry-out
result  out  WIDTH  final sum/difference
cout  out  1  final carry-out; for sub, 1 = no borrow (A >= B unsigned)
ovf  out  1  two's-complement signed overflow
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync-released use): state=IDLE. busy, done, cout, ovf = 0. result = 0. add_a/add_b/add_cin = 0. Internal registers = 0.
- States: IDLE, RUN, DONE. busy = (state==RUN).
- Acceptance: start=1 at an edge while state is IDLE or DONE. The block then:
  - latches a_reg=op_a;
  - latches b_reg = sub ? ~op_b : op_b;
  - sets carry = sub ? 1 : op_cin;
  - sets idx=0, state=RUN.
- start while in RUN is ignored. No queuing.
- RUN, each cycle: add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry.
- RUN, at each edge: work[4*idx+:4] <= add_sum; carry <= add_cout; idx <= idx+1.
- After the edge processing idx=NIBBLES-1, state=DONE.
- At that same edge:
  - result <= full work word, including the final nibble;
  - cout <= add_cout;
  - ovf <= (a_reg[MSB]==b_reg[MSB]) && (sum[MSB]!=a_reg[MSB]), where sum[MSB] is bit 3 of the final add_sum;
  - done <= 1.
- Latency: the acceptance edge is E0. done rises at edge E(NIBBLES), e.g. E4 for WIDTH=16. busy is high for exactly NIBBLES cycles.
- DONE lasts one cycle, then goes to IDLE. If start is also accepted in the DONE cycle, it goes straight to RUN. This gives back-to-back throughput of one op per NIBBLES+1 cycles.
- done is low in every cycle except the DONE cycle.
- result/cout/ovf change only at the edge entering DONE. They hold through IDLE and any following RUN.
- In IDLE and DONE: add_a, add_b, add_cin = 0.
- Carry fully ripples across nibbles through the carry register. No combinational path exists from add_cout to add_cin.
- Reset mid-RUN: immediate return to reset values. The aborted op produces no done. The next start behaves normally.

Test Plan:
- WIDTH=16, bench models the slice as a combinational 4-bit adder. Start with op_a=0x1234, op_b=0x0F0F, op_cin=0, sub=0 -> busy high 4 cycles, done at E4, result=0x2143, cout=0, ovf=0. Check add_a sequence 4,3,2,1.
- op_a=0xFFFF, op_b=0xFFFF, op_cin=1, sub=0 -> result=0xFFFF, cout=1, ovf=0. Check add_cin=1 on every RUN cycle.
- sub=1 with op_a=0x0005, op_b=0x0007 -> result=0xFFFE, cout=0, ovf=0. Then sub=1 with op_a=0x8000, op_b=0x0001, op_cin=0 -> result=0x7FFF, cout=1, ovf=1.
- op_a=0x7FFF, op_b=0x0001, sub=0 -> result=0x8000, cout=0, ovf=1.
- Pulse start at E2 of an op -> ignored, result unchanged by it. Hold start=1 continuously across two ops -> done pulses at E4 and E9. Results match both operand pairs.
- Drive rst_n low between E2 and E3 of an op -> busy, done, result go 0 immediately with no clock. No done follows. Next op 0x0001+0x0001 -> result=0x0002.
